// File: rtl/ram_dp_be_if.sv
// Request/response bundle for the ram_dp_be dual-port byte-enable RAM.
// The master drives the requests on ports A and B; the slave (the RAM) returns read data, ready and coll.
interface ram_dp_be_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned NBYTES     = 4
);
  localparam int unsigned DATA_WIDTH = NBYTES * BYTE_WIDTH;

  logic                  ready;
  logic                  en_a;
  logic [NBYTES-1:0]     we_a;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [DATA_WIDTH-1:0] wdata_a;
  logic [DATA_WIDTH-1:0] rdata_a;
  logic                  rvalid_a;
  logic                  en_b;
  logic [NBYTES-1:0]     we_b;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] wdata_b;
  logic [DATA_WIDTH-1:0] rdata_b;
  logic                  rvalid_b;
  logic                  coll;

  modport master (
    input  ready, rdata_a, rvalid_a, rdata_b, rvalid_b, coll,
    output en_a, we_a, addr_a, wdata_a, en_b, we_b, addr_b, wdata_b
  );

  modport slave (
    output ready, rdata_a, rvalid_a, rdata_b, rvalid_b, coll,
    input  en_a, we_a, addr_a, wdata_a, en_b, we_b, addr_b, wdata_b
  );
endinterface

// File: rtl/ram_dp_be.sv
// True dual-port RAM with per-byte write enables, read-first semantics, 1- or 2-cycle read latency
// and a registered collision flag. Define RAM_DP_CLEAR_ON_RESET_EN to zero the array after reset.
module ram_dp_be #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned BYTE_WIDTH   = 8,
  parameter int unsigned NBYTES       = 4,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  ram_dp_be_if.slave     bus
);
  localparam int unsigned DATA_WIDTH = NBYTES * BYTE_WIDTH;
  localparam int unsigned DEPTH      = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  ready;
  logic                  acc_a;
  logic                  acc_b;
  logic [DATA_WIDTH-1:0] rdata_a_q;
  logic [DATA_WIDTH-1:0] rdata_b_q;
  logic                  rvalid_a_q;
  logic                  rvalid_b_q;
  logic                  coll_q;

  assign acc_a = bus.en_a && ready && rst_n;
  assign acc_b = bus.en_b && ready && rst_n;

`ifdef RAM_DP_CLEAR_ON_RESET_EN
  typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_READY} state_t;

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q;
  logic [ADDR_WIDTH-1:0] clr_addr_d;
  logic                  clr_we;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RESET;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Address 0 is written on the first edge out of reset so ready rises after exactly DEPTH cycles.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_we     = 1'b0;
    case (state_q)
      ST_RESET, ST_CLEAR: begin
        if (rst_n) begin
          clr_we     = 1'b1;
          clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
          state_d    = (clr_addr_q == '1) ? ST_READY : ST_CLEAR;
        end
      end
      ST_READY: ;
      default:  state_d = ST_RESET;
    endcase
  end

  assign ready = (state_q == ST_READY);
`else
  logic ready_q;

  always_ff @(posedge clk) begin
    if (!rst_n) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

  assign ready = ready_q;
`endif

  // Port B lanes are written first so that port A's later assignment wins on a shared lane.
  always_ff @(posedge clk) begin
`ifdef RAM_DP_CLEAR_ON_RESET_EN
    if (clr_we) begin
      mem[clr_addr_q] <= '0;
    end else
`endif
    begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (acc_b && bus.we_b[i])
          mem[bus.addr_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.wdata_b[i*BYTE_WIDTH +: BYTE_WIDTH];
        if (acc_a && bus.we_a[i])
          mem[bus.addr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.wdata_a[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) coll_q <= 1'b0;
    else        coll_q <= acc_a && acc_b && (bus.addr_a == bus.addr_b) &&
                          ((bus.we_a != '0) || (bus.we_b != '0));
  end

  if (READ_LATENCY == 1) begin : g_lat1
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rvalid_a_q <= 1'b0;
        rvalid_b_q <= 1'b0;
        rdata_a_q  <= '0;
        rdata_b_q  <= '0;
      end else begin
        rvalid_a_q <= acc_a;
        rvalid_b_q <= acc_b;
        if (acc_a) rdata_a_q <= mem[bus.addr_a];
        if (acc_b) rdata_b_q <= mem[bus.addr_b];
      end
    end
  end else if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] pipe_a_q;
    logic [DATA_WIDTH-1:0] pipe_b_q;
    logic                  pv_a_q;
    logic                  pv_b_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        pv_a_q     <= 1'b0;
        pv_b_q     <= 1'b0;
        pipe_a_q   <= '0;
        pipe_b_q   <= '0;
        rvalid_a_q <= 1'b0;
        rvalid_b_q <= 1'b0;
        rdata_a_q  <= '0;
        rdata_b_q  <= '0;
      end else begin
        pv_a_q     <= acc_a;
        pv_b_q     <= acc_b;
        if (acc_a)  pipe_a_q  <= mem[bus.addr_a];
        if (acc_b)  pipe_b_q  <= mem[bus.addr_b];
        rvalid_a_q <= pv_a_q;
        rvalid_b_q <= pv_b_q;
        if (pv_a_q) rdata_a_q <= pipe_a_q;
        if (pv_b_q) rdata_b_q <= pipe_b_q;
      end
    end
  end else begin : g_bad_latency
    $error("ram_dp_be: READ_LATENCY must be 1 or 2");
  end

  assign bus.ready    = ready;
  assign bus.rdata_a  = rdata_a_q;
  assign bus.rdata_b  = rdata_b_q;
  assign bus.rvalid_a = rvalid_a_q;
  assign bus.rvalid_b = rvalid_b_q;
  assign bus.coll     = coll_q;
endmodule

// File: tb/tb_ram_dp_be.sv
// Self-checking bench for ram_dp_be: one instance per read latency, shared stimulus, array-based reference model.
module tb_ram_dp_be;
  localparam int unsigned AW = 4;
  localparam int unsigned BW = 8;
  localparam int unsigned NB = 4;
  localparam int unsigned DW = NB * BW;
  localparam int unsigned DEPTH = 2 ** AW;
`ifdef RAM_DP_CLEAR_ON_RESET_EN
  localparam int unsigned EXP_WAIT = DEPTH;
  localparam bit CLR = 1'b1;
`else
  localparam int unsigned EXP_WAIT = 1;
  localparam bit CLR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          en_a, en_b;
  logic [NB-1:0] we_a, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;

  logic          rv_a [2];
  logic          rv_b [2];
  logic          rdy  [2];
  logic          cl   [2];
  logic [DW-1:0] rd_a [2];
  logic [DW-1:0] rd_b [2];

  ram_dp_be_if #(.ADDR_WIDTH(AW), .BYTE_WIDTH(BW), .NBYTES(NB)) bus [2] ();

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign bus[g].en_a    = en_a;
    assign bus[g].we_a    = we_a;
    assign bus[g].addr_a  = addr_a;
    assign bus[g].wdata_a = wdata_a;
    assign bus[g].en_b    = en_b;
    assign bus[g].we_b    = we_b;
    assign bus[g].addr_b  = addr_b;
    assign bus[g].wdata_b = wdata_b;
    assign rv_a[g] = bus[g].rvalid_a;
    assign rv_b[g] = bus[g].rvalid_b;
    assign rd_a[g] = bus[g].rdata_a;
    assign rd_b[g] = bus[g].rdata_b;
    assign rdy[g]  = bus[g].ready;
    assign cl[g]   = bus[g].coll;

    ram_dp_be #(.ADDR_WIDTH(AW), .BYTE_WIDTH(BW), .NBYTES(NB), .READ_LATENCY(g + 1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus[g])
    );
  end

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: word array plus per-lane "has been written" flags.
  typedef struct { bit v; logic [DW-1:0] d; logic [DW-1:0] m; } rec_t;
  logic [DW-1:0] mmem [DEPTH];
  logic [NB-1:0] mkn  [DEPTH];
  rec_t          qa[$], qb[$];
  logic [DW-1:0] hold_d [2][2];
  logic [DW-1:0] hold_m [2][2];
  bit            ready_m = 1'b0;
  bit            coll_m  = 1'b0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] lane_mask(input logic [NB-1:0] k);
    logic [DW-1:0] m = '0;
    for (int i = 0; i < int'(NB); i++) m[i*BW +: BW] = {BW{k[i]}};
    return m;
  endfunction

  task automatic cycle(input bit ea, input logic [NB-1:0] wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                       input bit eb, input logic [NB-1:0] wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    bit   acc_a, acc_b;
    rec_t ra, rb, r;
    en_a = ea; we_a = wa; addr_a = aa; wdata_a = da;
    en_b = eb; we_b = wb; addr_b = ab; wdata_b = db;
    acc_a = ea && ready_m && rst_n;
    acc_b = eb && ready_m && rst_n;
    ra.v = acc_a; ra.d = mmem[aa]; ra.m = lane_mask(mkn[aa]);
    rb.v = acc_b; rb.d = mmem[ab]; rb.m = lane_mask(mkn[ab]);
    for (int i = 0; i < int'(NB); i++) begin
      if (acc_a && wa[i]) begin
        mmem[aa][i*BW +: BW] = da[i*BW +: BW];
        mkn[aa][i] = 1'b1;
      end else if (acc_b && wb[i] && !(acc_a && aa == ab && wa[i])) begin
        mmem[ab][i*BW +: BW] = db[i*BW +: BW];
        mkn[ab][i] = 1'b1;
      end
    end
    if (acc_b) begin
      for (int i = 0; i < int'(NB); i++)
        if (wb[i] && !(acc_a && aa == ab && wa[i])) mmem[ab][i*BW +: BW] = db[i*BW +: BW];
    end
    coll_m = acc_a && acc_b && (aa == ab) && ((wa != '0) || (wb != '0));
    if (!rst_n) begin
      qa.delete(); qb.delete();
      qa.push_back(ra); qb.push_back(rb);
      for (int p = 0; p < 2; p++)
        for (int l = 0; l < 2; l++) begin hold_d[p][l] = '0; hold_m[p][l] = '1; end
      ready_m = 1'b0;
      coll_m  = 1'b0;
    end
    qa.push_back(ra); qb.push_back(rb);
    while (qa.size() > 2) begin void'(qa.pop_front()); void'(qb.pop_front()); end
    @(posedge clk); #1;
    for (int l = 0; l < 2; l++) begin
      r = qa[qa.size() - 1 - l];
      if (r.v) begin hold_d[0][l] = r.d; hold_m[0][l] = r.m; end
      chk($sformatf("rvalid_a_L%0d", l + 1), DW'(rv_a[l]), DW'(r.v));
      if (hold_m[0][l] != '0)
        chk($sformatf("rdata_a_L%0d", l + 1), rd_a[l] & hold_m[0][l], hold_d[0][l] & hold_m[0][l]);
      r = qb[qb.size() - 1 - l];
      if (r.v) begin hold_d[1][l] = r.d; hold_m[1][l] = r.m; end
      chk($sformatf("rvalid_b_L%0d", l + 1), DW'(rv_b[l]), DW'(r.v));
      if (hold_m[1][l] != '0)
        chk($sformatf("rdata_b_L%0d", l + 1), rd_b[l] & hold_m[1][l], hold_d[1][l] & hold_m[1][l]);
      chk($sformatf("coll_L%0d", l + 1), DW'(cl[l]), DW'(coll_m));
      chk($sformatf("ready_L%0d", l + 1), DW'(rdy[l]), DW'(ready_m));
    end
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic wait_ready();
    int cnt = 0;
    while (rdy[0] !== 1'b1 && cnt < int'(4 * DEPTH)) begin
      cnt++;
      @(posedge clk); #1;
    end
    chk("ready_wait_cycles", DW'(cnt), DW'(EXP_WAIT));
    chk("ready_L2_after_wait", DW'(rdy[1]), DW'(1));
    ready_m = 1'b1;
    if (CLR)
      for (int a = 0; a < int'(DEPTH); a++) begin mmem[a] = '0; mkn[a] = '1; end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) idle();
    rst_n = 1'b1;
    wait_ready();
  endtask

  task automatic rand_cycle(input bit reads_only);
    logic [NB-1:0] wa, wb;
    wa = ($urandom_range(1) == 0 || reads_only) ? '0 : NB'($urandom);
    wb = ($urandom_range(1) == 0 || reads_only) ? '0 : NB'($urandom);
    cycle(reads_only || $urandom_range(3) != 0, wa, AW'($urandom), DW'($urandom),
          reads_only || $urandom_range(3) != 0, wb, AW'($urandom), DW'($urandom));
  endtask

  initial begin
    en_a = 1'b0; en_b = 1'b0; we_a = '0; we_b = '0;
    addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
    for (int a = 0; a < int'(DEPTH); a++) begin mmem[a] = '0; mkn[a] = '0; end
    for (int p = 0; p < 2; p++)
      for (int l = 0; l < 2; l++) begin hold_d[p][l] = '0; hold_m[p][l] = '0; end
    begin
      rec_t z;
      z.v = 1'b0; z.d = '0; z.m = '0;
      qa.push_back(z); qa.push_back(z); qb.push_back(z); qb.push_back(z);
    end
    do_reset(3);

    // Full-word write, cross-port read on the next cycle.
    cycle(1'b1, 4'hF, 4'd5, 32'hDEADBEEF, 1'b0, '0, '0, '0);
    cycle(1'b0, '0, '0, '0, 1'b1, 4'h0, 4'd5, '0);
    chk("plan_rd5_L1", rd_b[0], 32'hDEADBEEF);
    idle();
    chk("plan_rd5_L2", rd_b[1], 32'hDEADBEEF);

    // Partial byte-enable write.
    cycle(1'b1, 4'hF, 4'd7, 32'h11223344, 1'b0, '0, '0, '0);
    cycle(1'b1, 4'b0101, 4'd7, 32'hAABBCCDD, 1'b0, '0, '0, '0);
    cycle(1'b1, 4'h0, 4'd7, '0, 1'b0, '0, '0, '0);
    idle();
    chk("plan_be_L1", rd_a[0], 32'h11BB33DD);
    chk("plan_be_L2", rd_a[1], 32'h11BB33DD);

    // Write-write collision: lane 0 from A, lane 1 from B.
    cycle(1'b1, 4'hF, 4'd3, 32'h0, 1'b0, '0, '0, '0);
    cycle(1'b1, 4'b0001, 4'd3, 32'h000000FF, 1'b1, 4'b0011, 4'd3, 32'h0000FF00);
    chk("plan_ww_coll", DW'(cl[0]), DW'(1));
    idle();
    chk("plan_ww_coll_drop", DW'(cl[0]), DW'(0));
    cycle(1'b0, '0, '0, '0, 1'b1, 4'h0, 4'd3, '0);
    idle();
    chk("plan_ww_data_L2", rd_b[1], 32'h0000FFFF);

    // Write-read collision returns old data; read-read does not collide.
    cycle(1'b1, 4'hF, 4'd9, 32'hCAFEF00D, 1'b0, '0, '0, '0);
    cycle(1'b1, 4'hF, 4'd9, 32'h12345678, 1'b1, 4'h0, 4'd9, '0);
    chk("plan_wr_coll", DW'(cl[1]), DW'(1));
    idle();
    chk("plan_wr_old_L1", rd_b[0], 32'hCAFEF00D);
    chk("plan_wr_old_L2", rd_b[1], 32'hCAFEF00D);
    cycle(1'b1, 4'h0, 4'd9, '0, 1'b1, 4'h0, 4'd9, '0);
    chk("plan_rr_no_coll", DW'(cl[0]), DW'(0));
    idle();
    chk("plan_rr_data", rd_a[1], 32'h12345678);

    repeat (400) rand_cycle(1'b0);

    // Reset while reads are in flight.
    repeat (8) rand_cycle(1'b1);
    rst_n = 1'b0;
    cycle(1'b1, 4'h0, 4'd1, '0, 1'b1, 4'h0, 4'd2, '0);
    idle();
    rst_n = 1'b1;
    wait_ready();
    repeat (3) idle();

    // Reset re-asserted part-way through the post-reset sequence.
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    repeat (7) begin @(posedge clk); #1; end
    do_reset(1);
    for (int a = 0; a < int'(DEPTH); a++)
      cycle(1'b1, 4'h0, AW'(a), '0, 1'b1, 4'h0, AW'(int'(DEPTH) - 1 - a), '0);
    repeat (2) idle();

    repeat (200) rand_cycle(1'b0);
    repeat (2) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_dp_be.md
# ram_dp_be

Parametrised true dual-port RAM with multi-byte words, per-byte write enables, a selectable 1- or 2-cycle read pipeline with per-port read-valid strobes, deterministic same-address collision resolution and a registered collision flag. It is the next-generation replacement for the byte-wide dual-port RAM behind the `ram_if` master/slave modports. It serves as backing store for the AXI slave memory and per-core local memories.

## Interface
- `ADDR_WIDTH`, 10: word address width; depth = 2^ADDR_WIDTH words.
- `BYTE_WIDTH`, 8: bits per byte lane.
- `NBYTES`, 4: byte lanes per word; DATA_WIDTH = NBYTES*BYTE_WIDTH.
- `READ_LATENCY`, 1: 1 or 2 cycles from accepted read to `rvalid`; any other value is an elaboration error.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ready`  out  1  RAM accepts requests.
- `en_a` / `en_b`  in  1  request on port A / B.
- `we_a` / `we_b`  in  NBYTES  per-lane write enables; all-zero with `en` set = read.
- `addr_a` / `addr_b`  in  ADDR_WIDTH  word address.
- `wdata_a` / `wdata_b`  in  DATA_WIDTH  write data; lane i = bits [i*BYTE_WIDTH +: BYTE_WIDTH].
- `rdata_a` / `rdata_b`  out  DATA_WIDTH  read data, valid with `rvalid_x`.
- `rvalid_a` / `rvalid_b`  out  1  read data strobe, one cycle per accepted read.
- `coll`  out  1  registered pulse: same-address conflict in previous cycle.

## Operation
- Request accepted on a port when `en_x && ready`; `en_x` while `ready`=0 is ignored, producing no write and no `rvalid`.
- Write (`we_x` != 0): only lanes with `we_x[i]`=1 updated; other lanes retain contents.
- Read (`we_x` = 0): word at `addr_x` returned after READ_LATENCY cycles.
- Mixed access: a write request also returns data. It is read-first, giving pre-write contents, with `rvalid_x` asserted READ_LATENCY cycles later.
- Cross-port read of an address the other port writes in the same cycle returns old data (read-first).
- Write–write collision on the same address: per lane, port A wins where both `we_a[i]` and `we_b[i]` are set. Lanes written by only one port take that port's data.
- `coll` is set the cycle after both ports are accepted with `addr_a == addr_b` and at least one `we` non-zero. It is not set for read–read.
- Reset clears `rvalid_a`, `rvalid_b`, `rdata_a`, `rdata_b` (to 0), `coll` (to 0) and the read pipeline. Array contents are untouched unless RAM_DP_CLEAR_ON_RESET_EN is defined.
- Reset asserted mid-read: in-flight `rvalid` is dropped and never emitted.

## Timing
- READ_LATENCY=1: request at edge N; `rdata`/`rvalid` valid after edge N+1, i.e. during cycle N+1.
- READ_LATENCY=2: extra output register; `rvalid` after edge N+2. Back-to-back reads each cycle give `rvalid` every cycle, in order.
- `rdata_x` holds its last value when `rvalid_x`=0.
- Write visible to either port on a read issued the next cycle or later.
- `ready`: 0 during reset; 1 from the first cycle after `rst_n` deasserts when the clear feature is disabled.
- `coll` is high for exactly one cycle per colliding cycle.

## Configuration
- `RAM_DP_CLEAR_ON_RESET_EN` defined: FSM states RESET → CLEAR → READY.
  - RESET holds while `rst_n`=0.
  - CLEAR writes zero to address 0..2^ADDR_WIDTH-1 through port A, one word per cycle, with `ready`=0.
  - On the last address wrap the FSM enters READY and sets `ready`=1. `ready` rises 2^ADDR_WIDTH cycles after reset release.
  - Reset during CLEAR restarts from address 0.
- Not defined: no clear FSM. `ready` is registered to 1 one cycle after reset release, and contents are uninitialised.

## Test plan
- Reset, wait `ready`; A writes 0xDEADBEEF to addr 5 with `we_a`=4'hF; B reads addr 5 next cycle → `rdata_b`=0xDEADBEEF with `rvalid_b` at READ_LATENCY, for both latency builds.
- Addr 7 holds 0x11223344; A writes 0xAABBCCDD with `we_a`=4'b0101 → later read = 0x11BB33DD.
- Same cycle, A and B write addr 3: A 0x000000FF with we 4'b0001, B 0x0000FF00 with we 4'b0011, old value 0 → result 0x0000FFFF (lane 0 from A); `coll`=1 for one cycle.
- Same cycle, A writes 0x12345678 to addr 9 (old 0xCAFEF00D) while B reads addr 9 → `rdata_b`=0xCAFEF00D; `coll`=1. Simultaneous reads at the same address → `coll`=0.
- Issue reads on every cycle for 8 cycles, then pulse `rst_n` low while two are in flight → no `rvalid` after reset; all outputs 0.
- Clear build, ADDR_WIDTH=4: `ready`=0 for 16 cycles after reset release; then all 16 addresses read 0. Reset at clear step 7 → `ready` again takes a full 16 cycles.
